// File: rtl/slot_scheduler.sv
// slot_scheduler: round-robin time-slot scheduler for one shared timed resource.
// Grants are one-hot and registered. Each slot is bounded by an internal slot counter.
// Guard cycles are inserted between consecutive owners.
// Optional build macro SLOT_SCHED_STATS_EN adds per-requester saturating timeout
// counters, read through stat_sel/stat_val.
module slot_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int CNT_W     = 8,
    parameter int GUARD_CYC = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    input  logic [CNT_W-1:0]           slot_len,
`ifdef SLOT_SCHED_STATS_EN
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
    output logic [7:0]                 stat_val,
`endif
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       busy,
    output logic [CNT_W-1:0]           slot_count,
    output logic                       timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] GNT_ONE    = NUM_REQ'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]         GUARD_LAST = 4'(GUARD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t               state_r;
    logic [NUM_REQ-1:0]   gnt_r;
    logic [IDX_W-1:0]     gnt_idx_r;
    logic                 busy_r;
    logic [CNT_W-1:0]     slot_count_r;
    logic                 timeout_r;
    logic [IDX_W-1:0]     rr_ptr_r;
    logic [CNT_W-1:0]     len_r;
    logic [3:0]           guard_cnt_r;

    logic                 win_found_s;
    logic [IDX_W-1:0]     win_idx_s;
    logic [IDX_W-1:0]     cand_s;
    logic                 release_s;
    logic                 expire_s;
    logic                 to_evt_s;

    // Round-robin search: first asserted request at or above the pointer, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IDX_W{1'b0}};
        cand_s      = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = IDX_W'((int'(rr_ptr_r) + i) % NUM_REQ);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Owner release (explicit done or dropped request) and slot expiry; len 0 wraps to all-ones.
    assign release_s = done[gnt_idx_r] | ~req[gnt_idx_r];
    assign expire_s  = (slot_count_r == (len_r - CNT_ONE));
    assign to_evt_s  = expire_s & ~release_s;

    // Scheduler FSM with registered grant, counter and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            gnt_r        <= {NUM_REQ{1'b0}};
            gnt_idx_r    <= {IDX_W{1'b0}};
            busy_r       <= 1'b0;
            slot_count_r <= {CNT_W{1'b0}};
            timeout_r    <= 1'b0;
            rr_ptr_r     <= {IDX_W{1'b0}};
            len_r        <= {CNT_W{1'b0}};
            guard_cnt_r  <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    slot_count_r <= {CNT_W{1'b0}};
                    timeout_r    <= 1'b0;
                    guard_cnt_r  <= 4'd0;
                    if (enable && win_found_s) begin
                        state_r   <= ST_GRANT;
                        gnt_r     <= GNT_ONE << win_idx_s;
                        gnt_idx_r <= win_idx_s;
                        busy_r    <= 1'b1;
                        len_r     <= slot_len;
                        rr_ptr_r  <= (win_idx_s == IDX_LAST) ? {IDX_W{1'b0}} : (win_idx_s + IDX_ONE);
                    end else begin
                        state_r <= ST_IDLE;
                        gnt_r   <= {NUM_REQ{1'b0}};
                        busy_r  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (release_s || expire_s) begin
                        state_r      <= ST_GUARD;
                        gnt_r        <= {NUM_REQ{1'b0}};
                        slot_count_r <= {CNT_W{1'b0}};
                        timeout_r    <= to_evt_s;
                        guard_cnt_r  <= 4'd0;
                    end else begin
                        slot_count_r <= slot_count_r + CNT_ONE;
                        timeout_r    <= 1'b0;
                    end
                end
                ST_GUARD: begin
                    gnt_r        <= {NUM_REQ{1'b0}};
                    slot_count_r <= {CNT_W{1'b0}};
                    timeout_r    <= 1'b0;
                    if (guard_cnt_r == GUARD_LAST) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        guard_cnt_r <= guard_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    gnt_r        <= {NUM_REQ{1'b0}};
                    busy_r       <= 1'b0;
                    slot_count_r <= {CNT_W{1'b0}};
                    timeout_r    <= 1'b0;
                    guard_cnt_r  <= 4'd0;
                end
            endcase
        end
    end

    assign gnt        = gnt_r;
    assign gnt_idx    = gnt_idx_r;
    assign busy       = busy_r;
    assign slot_count = slot_count_r;
    assign timeout    = timeout_r;

`ifdef SLOT_SCHED_STATS_EN
    logic [7:0] to_cnt_r [NUM_REQ];

    // Saturating per-requester timeout counters; gnt_idx still names the owner during the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                to_cnt_r[i] <= 8'd0;
            end
        end else if (timeout_r && (to_cnt_r[gnt_idx_r] != 8'hFF)) begin
            to_cnt_r[gnt_idx_r] <= to_cnt_r[gnt_idx_r] + 8'd1;
        end else begin
            to_cnt_r[gnt_idx_r] <= to_cnt_r[gnt_idx_r];
        end
    end

    assign stat_val = to_cnt_r[stat_sel];
`endif

endmodule

// File: tb/tb_slot_scheduler.sv
// Bench for slot_scheduler: directed scenarios plus a cycle-level reference model
// built from owner/elapsed/guard bookkeeping, compared every cycle.
module tb_slot_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int CNT_W     = 8;
    localparam int GUARD_CYC = 1;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       enable   = 1'b0;
    logic [3:0] req      = 4'b0000;
    logic [3:0] done     = 4'b0000;
    logic [7:0] slot_len = 8'd0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic [7:0] slot_count;
    logic       timeout;
`ifdef SLOT_SCHED_STATS_EN
    logic [1:0] stat_sel = 2'd0;
    logic [7:0] stat_val;
`endif

    slot_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .GUARD_CYC(GUARD_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .req        (req),
        .done       (done),
        .slot_len   (slot_len),
`ifdef SLOT_SCHED_STATS_EN
        .stat_sel   (stat_sel),
        .stat_val   (stat_val),
`endif
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .busy       (busy),
        .slot_count (slot_count),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: owner -1 means nobody holds the resource
    int m_owner   = -1;
    int m_ptr     = 0;
    int m_elapsed = 0;
    int m_len     = 0;
    int m_guard   = 0;
    int m_last    = 0;
    int m_to      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int w;
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_elapsed = 0; m_len = 0;
            m_guard = 0; m_last = 0; m_to = 0;
        end else if (m_owner >= 0) begin
            bit rel;
            bit expd;
            rel  = done[m_owner] || !req[m_owner];
            expd = (m_elapsed == m_len - 1);
            if (rel || expd) begin
                m_to      = (expd && !rel) ? 1 : 0;
                m_owner   = -1;
                m_elapsed = 0;
                m_guard   = GUARD_CYC;
            end else begin
                m_elapsed = m_elapsed + 1;
                m_to      = 0;
            end
        end else if (m_guard > 0) begin
            m_guard = m_guard - 1;
            m_to    = 0;
        end else begin
            m_to = 0;
            w    = -1;
            if (enable) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (w < 0 && req[(m_ptr + i) % NUM_REQ]) w = (m_ptr + i) % NUM_REQ;
                end
            end
            if (w >= 0) begin
                m_owner   = w;
                m_last    = w;
                m_ptr     = (w + 1) % NUM_REQ;
                m_elapsed = 0;
                m_len     = (slot_len == 8'd0) ? 256 : int'(slot_len);
            end
        end
    endtask

    // Model advance on each rising edge, comparison 2 ns later.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #2;
            chk("m_gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
            chk("m_gnt_idx", int'(gnt_idx), m_last);
            chk("m_busy", int'(busy), (m_owner >= 0 || m_guard > 0) ? 1 : 0);
            chk("m_slot_count", int'(slot_count), (m_owner >= 0) ? m_elapsed : 0);
            chk("m_timeout", int'(timeout), m_to);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = 4'b0000; done = 4'b0000; enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n, gap, to_n, cnt, mx, bad;
        logic [3:0] prev;
        int order [5];
        #2 rst_n = 1'b0;

        // T1: reset state, single expiry, guard, round-robin to next requester
        do_reset();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_idx", int'(gnt_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(slot_count), 0);
        chk("rst_to", int'(timeout), 0);
        req = 4'b0101; enable = 1'b1; slot_len = 8'd3;
        @(negedge clk); chk("t1_gnt0", int'(gnt), 1); chk("t1_sc0", int'(slot_count), 0); chk("t1_busy", int'(busy), 1);
        @(negedge clk); chk("t1_sc1", int'(slot_count), 1);
        @(negedge clk); chk("t1_sc2", int'(slot_count), 2); chk("t1_to_early", int'(timeout), 0);
        @(negedge clk); chk("t1_gnt_off", int'(gnt), 0); chk("t1_to", int'(timeout), 1); chk("t1_guard_busy", int'(busy), 1);
        @(negedge clk); chk("t1_idle_busy", int'(busy), 0); chk("t1_to_clr", int'(timeout), 0);
        @(negedge clk); chk("t1_gnt2", int'(gnt), 4); chk("t1_idx2", int'(gnt_idx), 2);
        req = 4'b0000;

        // T2: all requesting, done at slot_count 1 -> order 0,1,2,3,0, gap 2
        do_reset();
        req = 4'b1111; enable = 1'b1; slot_len = 8'd10;
        n = 0; gap = 0; to_n = 0; prev = 4'b0000;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge clk);
            if (gnt != 4'b0000 && prev == 4'b0000) begin
                order[n] = int'(gnt_idx);
                if (n > 0) chk("t2_gap", gap, 2);
                n++;
            end
            if (gnt == 4'b0000) gap++; else gap = 0;
            prev = gnt;
            if (timeout) to_n++;
            done = (slot_count == 8'd1) ? gnt : 4'b0000;
        end
        done = 4'b0000;
        chk("t2_grants", n, 5);
        chk("t2_ord0", order[0], 0);
        chk("t2_ord1", order[1], 1);
        chk("t2_ord2", order[2], 2);
        chk("t2_ord3", order[3], 3);
        chk("t2_ord4", order[4], 0);
        chk("t2_no_to", to_n, 0);

        // T3: slot_len 0 -> 256-cycle slot, one timeout
        do_reset();
        req = 4'b0001; enable = 1'b1; slot_len = 8'd0;
        cnt = 0; mx = 0; to_n = 0;
        for (int c = 0; c < 270; c++) begin
            @(negedge clk);
            if (gnt == 4'b0001) cnt++;
            if (int'(slot_count) > mx) mx = int'(slot_count);
            if (timeout) begin to_n++; req = 4'b0000; end
        end
        chk("t3_len", cnt, 256);
        chk("t3_max", mx, 255);
        chk("t3_to", to_n, 1);

        // T4: foreign done ignored; owner done coinciding with expiry suppresses timeout
        do_reset();
        req = 4'b0011; enable = 1'b1; slot_len = 8'd2;
        @(negedge clk); chk("t4_gnt", int'(gnt), 1); done = 4'b0010;
        @(negedge clk); chk("t4_ignored", int'(gnt), 1); chk("t4_sc1", int'(slot_count), 1); done = 4'b0001;
        @(negedge clk); chk("t4_released", int'(gnt), 0); chk("t4_no_to", int'(timeout), 0); chk("t4_busy", int'(busy), 1);
        done = 4'b0000;

        // T5: enable dropped mid-slot, slot completes, no further grants
        do_reset();
        req = 4'b1111; enable = 1'b1; slot_len = 8'd5;
        @(negedge clk);
        @(negedge clk); chk("t5_sc1", int'(slot_count), 1); enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_sc4", int'(slot_count), 4); chk("t5_gnt", int'(gnt), 1);
        @(negedge clk); chk("t5_to", int'(timeout), 1); chk("t5_off", int'(gnt), 0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (gnt != 4'b0000) bad++;
        end
        chk("t5_no_grant", bad, 0);

        // T6: asynchronous reset mid-slot clears outputs at once
        do_reset();
        req = 4'b0001; enable = 1'b1; slot_len = 8'd10;
        repeat (3) @(negedge clk);
        chk("t6_sc2", int'(slot_count), 2);
        rst_n = 1'b0;
        #1;
        chk("t6_gnt", int'(gnt), 0); chk("t6_busy", int'(busy), 0);
        chk("t6_sc", int'(slot_count), 0); chk("t6_to", int'(timeout), 0);
        @(negedge clk); rst_n = 1'b1; req = 4'b0000;

`ifdef SLOT_SCHED_STATS_EN
        // T7: 300 timeouts on requester 2 saturate its counter
        do_reset();
        req = 4'b0100; enable = 1'b1; slot_len = 8'd1;
        to_n = 0;
        for (int c = 0; c < 1200 && to_n < 300; c++) begin
            @(negedge clk);
            if (timeout) to_n++;
        end
        chk("t7_pulses", to_n, 300);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        stat_sel = 2'd2; #1; chk("t7_sat", int'(stat_val), 255);
        stat_sel = 2'd1; #1; chk("t7_other", int'(stat_val), 0);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/slot_scheduler.md
Name: slot_scheduler

Overview:
- Round-robin time-slot scheduler that shares one timed resource between NUM_REQ requesters.
- Each grant is bounded by an internal CNT_W-bit slot counter, using the same enable-gated up-counter style as the codebase's counter blocks.
- Sits between requesting masters and the shared counter/datapath. Issues one-hot grants, enforces slot length, inserts guard cycles between owners.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 8, slot counter and slot length width
- GUARD_CYC, 1, idle cycles between consecutive grants (1..15)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  permits new arbitration; does not abort an active slot
- req  input  NUM_REQ  per-requester request, level
- done  input  NUM_REQ  per-requester release pulse; only the bit of the current owner is honoured
- slot_len  input  CNT_W  slot length in cycles, sampled at grant start; 0 means 2^CNT_W
- gnt  output  NUM_REQ  one-hot grant, registered
- gnt_idx  output  clog2(NUM_REQ)  index of current/last owner
- busy  output  1  high in GRANT and GUARD
- slot_count  output  CNT_W  cycles elapsed in current slot
- timeout  output  1  one-cycle pulse when a slot expires without release

Behaviour:
- Reset (async, rst_n low): gnt=0, gnt_idx=0, busy=0, slot_count=0, timeout=0, rr pointer=0, state=IDLE, latched length=0.
- FSM states: IDLE, GRANT, GUARD.
- IDLE, enable=1 and |req:
  - Winner = first set req bit searching from rr pointer upward, wrapping.
  - Next cycle: gnt[winner]=1, gnt_idx=winner, busy=1, slot_count=0, slot_len latched, state=GRANT.
  - rr pointer = (winner+1) mod NUM_REQ.
  - Latency req->gnt is 1 cycle.
- IDLE, enable=0 or no req: stay in IDLE, outputs hold reset values except gnt_idx, which holds.
- GRANT:
  - slot_count increments by 1 each cycle.
  - Slot ends on the first of:
    - done[gnt_idx]=1
    - req[gnt_idx]=0 (treated as release)
    - slot_count == latched_len-1 (len 0: slot_count == 2^CNT_W-1, the wrap point)
  - Expiry without release: timeout=1 for exactly the cycle after the last slot cycle.
  - Release and expiry in the same cycle: release wins, no timeout.
  - done bits of non-owners are ignored.
  - enable falling mid-slot has no effect; the slot runs to completion.
- Slot end: gnt=0 next cycle, slot_count=0, state=GUARD.
- GUARD: gnt=0, busy=1 for exactly GUARD_CYC cycles, then IDLE with busy=0. Arbitration resumes in IDLE, so the minimum gap between grants is GUARD_CYC+1 cycles.
- Invariants: gnt is always zero or one-hot; no grant outside GRANT; slot_count never exceeds latched_len-1.
- slot_len changes during GRANT have no effect on the current slot.
- rst_n asserted mid-slot: all outputs clear immediately (async); no timeout is generated.

Optional Feature:
- Macro: SLOT_SCHED_STATS_EN.
- When defined, adds:
  - Ports stat_sel (input, clog2(NUM_REQ)) and stat_val (output, 8).
  - Per-requester 8-bit saturating timeout counters, each incremented on that requester's timeout pulse, holding at 255.
  - stat_val = counter[stat_sel], combinational read.
  - Counters clear on reset only.
- When undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then req=4'b0101, enable=1, slot_len=3, no done -> gnt=0001 one cycle after req; slot_count 0,1,2; timeout pulse; gnt=0 for 1 guard cycle; then gnt=0100.
- req=4'b1111 held, done pulsed at slot_count=1 each slot -> grant order 0,1,2,3,0; no timeout; gap of 2 cycles between grants.
- slot_len=0, CNT_W=8, no done -> grant lasts 256 cycles; slot_count reaches 255; timeout=1 once.
- done[gnt_idx] and expiry in same cycle (slot_len=2, done at slot_count=1) -> timeout stays 0; done[other]=1 during slot -> ignored.
- enable dropped at slot_count=1 of a 5-cycle slot -> slot completes to 4; no new grant while enable=0 even with req=1111.
- rst_n low at slot_count=2 -> gnt, busy, slot_count clear immediately; with SLOT_SCHED_STATS_EN, 300 timeouts on requester 2 -> stat_sel=2 gives stat_val=255.
